// File: rtl/md_sched.sv
`default_nettype none
// ============================================================================
// Module   : md_sched
// Brief    : Multiply/divide scheduler and HI/LO owner for the 5-stage MIPS
//            pipeline. Runs mult/multu/div/divu over a fixed busy window,
//            applies mthi/mtlo directly, and requests a D-stage stall while
//            a HI/LO-dependent instruction would collide with the unit.
// Revision : 1.0 - initial release
// ============================================================================
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] c_OP_MULT  = 3'd1;
    localparam logic [2:0] c_OP_MULTU = 3'd2;
    localparam logic [2:0] c_OP_DIV   = 3'd3;
    localparam logic [2:0] c_OP_DIVU  = 3'd4;
    localparam logic [2:0] c_OP_MTHI  = 3'd5;
    localparam logic [2:0] c_OP_MTLO  = 3'd6;

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_MULT_N  = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_N   = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // Architectural and in-flight state
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;

    // Datapath wires
    logic               w_is_muldiv;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic               w_div_zero;
    logic [31:0]        w_den_s;
    logic [31:0]        w_den_u;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q_s;
    logic [31:0]        w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wr;
    logic [c_CNT_W-1:0] w_res_n;

    assign w_is_muldiv = (E_md_op >= c_OP_MULT) && (E_md_op <= c_OP_DIVU);
    assign start       = w_is_muldiv && !r_busy;
    assign stall       = D_md && (start || r_busy);
    assign busy        = r_busy;
    assign HI          = r_hi;
    assign LO          = r_lo;

    // Full-width products; operands are extended explicitly so both halves are exact
    assign w_prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign w_prod_u = {32'd0, E_A} * {32'd0, E_B};

    // Signed divide done on magnitudes; the sign fix-up afterwards makes the
    // 0x80000000 / -1 case wrap to 0x80000000 with remainder 0 on its own.
    assign w_a_neg    = E_A[31];
    assign w_b_neg    = E_B[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - E_A) : E_A;
    assign w_b_mag    = w_b_neg ? (32'd0 - E_B) : E_B;
    assign w_div_zero = (E_B == 32'd0);
    // A zero divisor is replaced by 1 so the datapath never produces X; the
    // result is discarded at commit anyway.
    assign w_den_s    = w_div_zero ? 32'd1 : w_b_mag;
    assign w_den_u    = w_div_zero ? 32'd1 : E_B;
    assign w_q_mag    = w_a_mag / w_den_s;
    assign w_r_mag    = w_a_mag % w_den_s;
    assign w_q_s      = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u      = E_A / w_den_u;
    assign w_r_u      = E_A % w_den_u;

    // Select the result, commit enable and busy length for the accepted op
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_wr = 1'b0;
        w_res_n  = c_MULT_N;
        case (E_md_op)
            c_OP_MULT: begin
                w_res_hi = w_prod_s[63:32];
                w_res_lo = w_prod_s[31:0];
                w_res_wr = 1'b1;
                w_res_n  = c_MULT_N;
            end
            c_OP_MULTU: begin
                w_res_hi = w_prod_u[63:32];
                w_res_lo = w_prod_u[31:0];
                w_res_wr = 1'b1;
                w_res_n  = c_MULT_N;
            end
            c_OP_DIV: begin
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
                w_res_wr = !w_div_zero;
                w_res_n  = c_DIV_N;
            end
            c_OP_DIVU: begin
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
                w_res_wr = !w_div_zero;
                w_res_n  = c_DIV_N;
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
                w_res_wr = 1'b0;
                w_res_n  = c_MULT_N;
            end
        endcase
    end

    // Launch, count down and commit operations; direct HI/LO moves when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else if (start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
            r_busy    <= 1'b1;
            r_cnt     <= w_res_n;
        end else if (r_busy) begin
            // Ops arriving here are ignored: the counter only ever counts down
            r_cnt <= r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
                r_busy <= 1'b0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else begin
            if (E_md_op == c_OP_MTHI) begin
                r_hi <= E_A;
            end
            if (E_md_op == c_OP_MTLO) begin
                r_lo <= E_A;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sched
// Brief    : Self-checking bench for md_sched. Directed scenarios followed by
//            random traffic, compared every cycle against a behavioural model
//            of the HI/LO unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk;
    logic        reset;
    logic [2:0]  E_md_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_md;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fail;

    // Reference model state
    int          m_left;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    bit          m_pwr;

    md_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .E_md_op(E_md_op),
        .E_A    (E_A),
        .E_B    (E_B),
        .D_md   (D_md),
        .start  (start),
        .busy   (busy),
        .stall  (stall),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of an accepted op, straight from the ISA rules
    function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] hi,
                                       output logic [31:0] lo, output bit wr, output int n);
        longint      ps;
        logic [63:0] pu;
        int          q;
        int          r;
        hi = 32'd0; lo = 32'd0; wr = 1'b0; n = MULT_N;
        case (op)
            OP_MULT: begin
                ps = longint'($signed(a)) * longint'($signed(b));
                hi = ps[63:32]; lo = ps[31:0]; wr = 1'b1; n = MULT_N;
            end
            OP_MULTU: begin
                pu = {32'd0, a} * {32'd0, b};
                hi = pu[63:32]; lo = pu[31:0]; wr = 1'b1; n = MULT_N;
            end
            OP_DIV: begin
                n = DIV_N;
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0; wr = 1'b1;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    lo = q; hi = r; wr = 1'b1;
                end
            end
            OP_DIVU: begin
                n = DIV_N;
                if (b == 32'd0) begin
                    wr = 1'b0;
                end else begin
                    lo = a / b; hi = a % b; wr = 1'b1;
                end
            end
            default: ;
        endcase
    endfunction

    // One clock cycle: drive, check against the model, clock, advance the model
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic dmd, input logic rst);
        bit x_start;
        bit x_busy;
        E_md_op = op; E_A = a; E_B = b; D_md = dmd; reset = rst;
        x_busy  = (m_left > 0);
        x_start = (op >= OP_MULT) && (op <= OP_DIVU) && !x_busy;
        #1;
        chk("start", {31'd0, start}, {31'd0, x_start});
        chk("busy",  {31'd0, busy},  {31'd0, x_busy});
        chk("stall", {31'd0, stall}, {31'd0, dmd & (x_start | x_busy)});
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        @(posedge clk);
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 1'b0;
        end else if (x_start) begin
            ref_result(op, a, b, m_phi, m_plo, m_pwr, m_left);
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pwr) begin
                m_hi = m_phi; m_lo = m_plo;
            end
        end else if (op == OP_MTHI) begin
            m_hi = a;
        end else if (op == OP_MTLO) begin
            m_lo = a;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) step(OP_NONE, 32'd0, 32'd0, dmd, 1'b0);
    endtask

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'd0;
            1: v = 32'h8000_0000;
            2: v = 32'hFFFF_FFFF;
            3: v = $urandom_range(0, 15);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        n_checks = 0; n_fail = 0;
        E_md_op = OP_NONE; E_A = '0; E_B = '0; D_md = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pwr = 1'b0;

        // Idle after reset with a HI/LO user in D: no stall
        step(OP_NONE, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);

        // mult -1 * 2
        step(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        idle(MULT_N, 1'b1);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFE);
        chk("mult_busy_done", {31'd0, busy}, 32'd0);

        // multu same operands
        step(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MULT_N, 1'b0);
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        // div -7 / 2, divu 7 / 2
        step(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        idle(DIV_N, 1'b1);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        step(OP_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("divu_hi", HI, 32'd1);
        chk("divu_lo", LO, 32'd3);

        // Preload, then divide by zero keeps HI/LO
        step(OP_MTHI, 32'h11, 32'd0, 1'b0, 1'b0);
        step(OP_MTLO, 32'h22, 32'd0, 1'b0, 1'b0);
        step(OP_DIVU, 32'd99, 32'd0, 1'b1, 1'b0);
        idle(DIV_N, 1'b1);
        chk("dz_hi", HI, 32'h11);
        chk("dz_lo", LO, 32'h22);

        // Signed overflow case
        step(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DIV_N, 1'b0);
        chk("ovf_hi", HI, 32'd0);
        chk("ovf_lo", LO, 32'h8000_0000);

        // Reset in busy cycle 3 aborts the mult with no late commit
        step(OP_MULT, 32'd1234, 32'd5678, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(OP_NONE, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(MULT_N + 2, 1'b0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);

        // Back-to-back: div starts the first idle cycle after a mult
        step(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        idle(MULT_N, 1'b1);
        chk("b2b_mult_lo", LO, 32'd12);
        step(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        idle(DIV_N, 1'b1);
        chk("b2b_div_hi", HI, 32'd2);
        chk("b2b_div_lo", LO, 32'd14);

        // Random traffic, including ops that arrive while busy and rare resets
        for (int i = 0; i < 400; i++) begin
            step(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 63) == 0));
        end
        idle(DIV_N + 1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
